// File: rtl/cpu_pkg.sv
// Shared sizes and types for the CPU register file and its read ports.
package cpu_pkg;
    localparam int N        = 16;
    localparam int SEL_LINE = 4;
    localparam int NUM_REGS = 2 ** SEL_LINE;

    typedef logic [SEL_LINE-1:0] reg_sel_t;
    typedef logic [N-1:0]        reg_word_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: value plus busy bit for the selected register.
// With WR_BYPASS_EN defined, a same-cycle writeback to the selected register is forwarded.
module regfile_read_port
    import cpu_pkg::*;
(
    input  reg_word_t [NUM_REGS-1:0] regs,
    input  logic      [NUM_REGS-1:0] busy,
    input  reg_sel_t                 sel,
`ifdef WR_BYPASS_EN
    input  logic                     wr_en,
    input  reg_sel_t                 wr_sel,
    input  reg_word_t                wr_val,
`endif
    output reg_word_t                val,
    output logic                     busy_o
);
`ifdef WR_BYPASS_EN
    logic hit;
    assign hit    = wr_en && (wr_sel == sel);
    // The writeback completes this edge, so the register is no longer pending.
    assign val    = hit ? wr_val : regs[sel];
    assign busy_o = hit ? 1'b0   : busy[sel];
`else
    assign val    = regs[sel];
    assign busy_o = busy[sel];
`endif
endmodule

// File: rtl/cpu_regfile.sv
// Register file with per-register busy scoreboard and issue stall.
// Optional same-cycle writeback forwarding: define WR_BYPASS_EN.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  reg_sel_t  wr_sel,
    input  reg_word_t wr_val,
    input  reg_sel_t  rs1_sel,
    input  reg_sel_t  rs2_sel,
    input  logic      rs1_used,
    input  logic      rs2_used,
    input  logic      iss_en,
    input  reg_sel_t  iss_sel,
    output reg_word_t rs1_val,
    output reg_word_t rs2_val,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      stall
);
    reg_word_t [NUM_REGS-1:0] regs_q, regs_d;
    logic      [NUM_REGS-1:0] busy_q, busy_d;
    logic                     dst_busy;
    logic                     iss_acc;

    regfile_read_port u_rd1 (
        .regs   (regs_q),
        .busy   (busy_q),
        .sel    (rs1_sel),
`ifdef WR_BYPASS_EN
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_val (wr_val),
`endif
        .val    (rs1_val),
        .busy_o (rs1_busy)
    );

    regfile_read_port u_rd2 (
        .regs   (regs_q),
        .busy   (busy_q),
        .sel    (rs2_sel),
`ifdef WR_BYPASS_EN
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_val (wr_val),
`endif
        .val    (rs2_val),
        .busy_o (rs2_busy)
    );

`ifdef WR_BYPASS_EN
    assign dst_busy = busy_q[iss_sel] & ~(wr_en & (wr_sel == iss_sel));
`else
    assign dst_busy = busy_q[iss_sel];
`endif

    assign stall   = iss_en & ((rs1_used & rs1_busy) | (rs2_used & rs2_busy) | dst_busy);
    assign iss_acc = iss_en & ~stall;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[wr_sel] = wr_val;
            busy_d[wr_sel] = 1'b0;
        end
        // Applied after the clear so a new producer of the same register keeps it pending.
        if (iss_acc)
            busy_d[iss_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench for cpu_regfile: driver queues expected read-port/stall values, monitor checks them.
module tb_cpu_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [15:0] wr_val;
    logic [3:0]  rs1_sel, rs2_sel;
    logic        rs1_used, rs2_used;
    logic        iss_en;
    logic [3:0]  iss_sel;
    logic [15:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy, stall;

    int total = 0;
    int bad   = 0;

`ifdef WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [15:0] v1;
        logic [15:0] v2;
        logic        b1;
        logic        b2;
        logic        st;
    } exp_t;

    exp_t exp_q[$];

    cpu_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_val   (wr_val),
        .rs1_sel  (rs1_sel),
        .rs2_sel  (rs2_sel),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic we, input logic [3:0] ws, input logic [15:0] wv,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic u1, input logic u2, input logic ie, input logic [3:0] is);
        wr_en = we; wr_sel = ws; wr_val = wv;
        rs1_sel = s1; rs2_sel = s2; rs1_used = u1; rs2_used = u2;
        iss_en = ie; iss_sel = is;
    endtask

    task automatic chk(input string nm, input logic [15:0] v1, input logic [15:0] v2,
                       input logic b1, input logic b2, input logic st);
        exp_t e;
        e.nm = nm; e.v1 = v1; e.v2 = v2; e.b1 = b1; e.b2 = b2; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are sampled mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (rs1_val !== e.v1 || rs2_val !== e.v2 || rs1_busy !== e.b1 ||
                rs2_busy !== e.b2 || stall !== e.st) begin
                bad++;
                $display("FAIL %s: got v1=%h v2=%h b1=%b b2=%b st=%b want v1=%h v2=%h b1=%b b2=%b st=%b",
                         e.nm, rs1_val, rs2_val, rs1_busy, rs2_busy, stall,
                         e.v1, e.v2, e.b1, e.b2, e.st);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drv(1, 3, 16'hBEEF, 0, 0, 0, 0, 1, 3);
        tick();
        tick();
        rst_n = 1'b1;

        drv(0, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("reset", 16'h0, 16'h0, 0, 0, 0);
        tick();

        drv(1, 5, 16'h1234, 5, 6, 0, 0, 0, 0);
        chk("wr_cycle", BYP ? 16'h1234 : 16'h0, 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 5, 5, 0, 0, 0, 0);
        chk("rd_both", 16'h1234, 16'h1234, 0, 0, 0);
        tick();
        drv(0, 0, 0, 5, 6, 0, 0, 0, 0);
        chk("rd_other", 16'h1234, 16'h0, 0, 0, 0);
        tick();

        drv(0, 0, 0, 7, 0, 0, 0, 1, 7);
        chk("iss7", 16'h0, 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 7, 0, 1, 0, 1, 8);
        chk("raw_stall", 16'h0, 16'h0, 1, 0, 1);
        tick();
        drv(1, 7, 16'h0077, 7, 0, 1, 0, 1, 8);
        if (BYP) chk("raw_wr_byp", 16'h0077, 16'h0, 0, 0, 0);
        else     chk("raw_wr", 16'h0, 16'h0, 1, 0, 1);
        tick();
        if (BYP) begin
            drv(0, 0, 0, 7, 8, 1, 0, 0, 8);
            chk("raw_after_byp", 16'h0077, 16'h0, 0, 1, 0);
        end else begin
            drv(0, 0, 0, 7, 8, 1, 0, 1, 8);
            chk("raw_retry", 16'h0077, 16'h0, 0, 0, 0);
        end
        tick();
        drv(0, 0, 0, 8, 0, 0, 0, 0, 0);
        chk("busy8", 16'h0, 16'h0, 1, 0, 0);
        tick();

        drv(0, 0, 0, 9, 0, 0, 0, 1, 9);
        chk("iss9", 16'h0, 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 9, 0, 0, 0, 1, 9);
        chk("waw_stall", 16'h0, 16'h0, 1, 0, 1);
        tick();
        drv(0, 0, 0, 9, 0, 0, 0, 0, 0);
        chk("waw_hold", 16'h0, 16'h0, 1, 0, 0);
        tick();

        drv(1, 9, 16'h0999, 9, 10, 0, 0, 1, 10);
        if (BYP) chk("diff_cycle", 16'h0999, 16'h0, 0, 0, 0);
        else     chk("diff_cycle", 16'h0, 16'h0, 1, 0, 0);
        tick();
        drv(0, 0, 0, 9, 10, 0, 0, 0, 0);
        chk("diff_after", 16'h0999, 16'h0, 0, 1, 0);
        tick();

        if (BYP) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 2);
            tick();
        end
        drv(1, 2, 16'h2222, 2, 0, 0, 0, 1, 2);
        if (BYP) chk("same_cycle", 16'h2222, 16'h0, 0, 0, 0);
        else     chk("same_cycle", 16'h0, 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 2, 0, 0, 0, 0, 0);
        chk("same_after", 16'h2222, 16'h0, 1, 0, 0);
        tick();

        drv(1, 4, 16'hA5A5, 4, 0, 0, 0, 0, 0);
        chk("byp_cycle", BYP ? 16'hA5A5 : 16'h0, 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 4, 0, 0, 0, 0, 0);
        chk("byp_next", 16'hA5A5, 16'h0, 0, 0, 0);
        tick();

        drv(1, 0, 16'h1111, 0, 0, 0, 0, 0, 0);
        chk("r0_cycle", BYP ? 16'h1111 : 16'h0, BYP ? 16'h1111 : 16'h0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_next", 16'h1111, 16'h1111, 0, 0, 0);
        tick();

        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
